// File: rtl/ysyx_20020207_lsu_if.sv
// LSU <-> memory bus interface: request channel (valid/ready) and response
// channel (single-cycle pulse with read data and error flag).
interface ysyx_20020207_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_20020207_lsu.sv
// Load/store unit: accepts one EXU access at a time, issues a single
// word-aligned bus transaction, and returns an extended load result.
// Optional feature: define LSU_MISALIGN_CHECK_EN to fail misaligned
// halfword/word accesses locally (lsu_err=1) without touching the bus.
module ysyx_20020207_lsu (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ctrl_valid,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [3:0]  i_wmask,
    input  logic [2:0]  i_load_ctrl,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    ysyx_20020207_lsu_if.master bus,
    output logic        o_lsu_valid,
    output logic [31:0] o_lsu_rdata,
    output logic        o_lsu_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_off;
    logic [2:0]  r_load_ctrl;
    logic        r_wen;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_wdata;
    logic [3:0]  r_req_wstrb;
    logic [31:0] r_lsu_rdata;
    logic        r_lsu_err;

    logic        w_mem;
    logic        w_misalign;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    // A simultaneous ren+wen is handled as a store: r_wen follows mem_wen only.
    assign w_mem = i_mem_ren | i_mem_wen;

`ifdef LSU_MISALIGN_CHECK_EN
    logic w_half;
    logic w_word;
    assign w_half = i_mem_wen ? (i_wmask == 4'b0011)
                              : (i_load_ctrl == 3'b001 || i_load_ctrl == 3'b101);
    assign w_word = i_mem_wen ? (i_wmask == 4'b1111) : (i_load_ctrl == 3'b010);
    assign w_misalign = w_mem & ((w_half & i_addr[0]) | (w_word & (|i_addr[1:0])));
`else
    assign w_misalign = 1'b0;
`endif

    // Lane placement for stores; anything shifted past the word is dropped.
    assign w_wstrb = i_wmask << i_addr[1:0];
    assign w_wdata = i_wdata << {i_addr[1:0], 3'b000};

    // Bring the addressed byte/halfword down to bit 0, then extend.
    assign w_shifted = bus.resp_rdata >> {r_off, 3'b000};

    // Load extension by kind; unknown codes pass the shifted word through.
    always_comb begin
        w_load = w_shifted;
        case (r_load_ctrl)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'd0, w_shifted[7:0]};
            3'b101:  w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    assign bus.req_valid = (r_state == S_REQ);
    assign bus.req_wen   = r_wen;
    assign bus.req_addr  = r_req_addr;
    assign bus.req_wdata = r_req_wdata;
    assign bus.req_wstrb = r_req_wstrb;
    assign o_lsu_valid   = (r_state == S_DONE);
    assign o_lsu_rdata   = r_lsu_rdata;
    assign o_lsu_err     = r_lsu_err;

    // Access FSM; request fields are latched once in IDLE so they stay stable in REQ.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_off       <= 2'd0;
            r_load_ctrl <= 3'd0;
            r_wen       <= 1'b0;
            r_req_addr  <= 32'd0;
            r_req_wdata <= 32'd0;
            r_req_wstrb <= 4'd0;
            r_lsu_rdata <= 32'd0;
            r_lsu_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_ctrl_valid) begin
                        if (w_mem && !w_misalign) begin
                            r_off       <= i_addr[1:0];
                            r_load_ctrl <= i_load_ctrl;
                            r_wen       <= i_mem_wen;
                            r_req_addr  <= {i_addr[31:2], 2'b00};
                            r_req_wdata <= i_mem_wen ? w_wdata : 32'd0;
                            r_req_wstrb <= i_mem_wen ? w_wstrb : 4'd0;
                            r_state     <= S_REQ;
                        end else begin
                            r_lsu_err <= w_misalign;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.req_ready) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.resp_valid) begin
                        r_lsu_err <= bus.resp_err;
                        if (!r_wen) r_lsu_rdata <= w_load;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_20020207_lsu.md
YSYX_20020207_LSU -- requirements
Module: ysyx_20020207_LSU

Interface
REQ-001 clock  in  1  single clock; all state updates on posedge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ctrl_valid  in  1  one-cycle pulse: EXU control/address valid.
REQ-004 mem_ren  in  1  load request, sampled with ctrl_valid.
REQ-005 mem_wen  in  1  store request, sampled with ctrl_valid.
REQ-006 wmask  in  4  store byte mask, low-aligned: 0001 sb, 0011 sh, 1111 sw.
REQ-007 load_ctrl  in  3  load kind: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-008 addr  in  32  byte address (ALU result).
REQ-009 wdata  in  32  store data, low-aligned (rs2).
REQ-010 req_valid  out  1  bus request valid.
REQ-011 req_ready  in  1  bus accepts request when high with req_valid.
REQ-012 req_wen  out  1  1 = write, 0 = read.
REQ-013 req_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-014 req_wdata  out  32  lane-shifted store data.
REQ-015 req_wstrb  out  4  lane-shifted byte strobe; 0 for reads.
REQ-016 resp_valid  in  1  one-cycle bus response pulse.
REQ-017 resp_rdata  in  32  read word, valid with resp_valid.
REQ-018 resp_err  in  1  bus error, valid with resp_valid.
REQ-019 lsu_valid  out  1  one-cycle completion pulse to writeback.
REQ-020 lsu_rdata  out  32  extended load result; held until next completion.
REQ-021 lsu_err  out  1  error flag, valid with lsu_valid.

Function
REQ-022 FSM states IDLE, REQ, WAIT, DONE; ctrl_valid SHALL be accepted only in IDLE and ignored otherwise.
REQ-023 IDLE + ctrl_valid with mem_ren|mem_wen: latch addr, wdata, wmask, load_ctrl, mem_wen into internal registers; next state REQ.
REQ-024 IDLE + ctrl_valid with neither mem_ren nor mem_wen: next state DONE; no bus activity, lsu_rdata unchanged, lsu_err=0.
REQ-025 If mem_ren and mem_wen are both set, the access SHALL be treated as a store.
REQ-026 REQ: req_valid=1 and all req_* fields SHALL be stable until the handshake completes; req_valid&req_ready moves to WAIT.
REQ-027 Outside REQ, req_valid=0.
REQ-028 Store lanes: req_wstrb = wmask << addr[1:0]; req_wdata = wdata << (8*addr[1:0]); bits shifted past bit 31 are discarded.
REQ-029 WAIT: resp_valid moves to DONE, capturing lsu_err=resp_err; a response arriving in the handshake cycle SHALL NOT be used.
REQ-030 Load data path: shift resp_rdata right by 8*addr[1:0], then lb/lh sign-extend from bit 7/15, lbu/lhu zero-extend, lw and any other code pass unmodified; register into lsu_rdata in the resp_valid cycle.
REQ-031 Stores SHALL leave lsu_rdata unchanged.
REQ-032 DONE: lsu_valid=1 for exactly one cycle, then IDLE; lsu_valid=0 in all other states.
REQ-033 Minimum latency from ctrl_valid to lsu_valid is 3 cycles for memory ops (req_ready and resp_valid asserted at the first legal cycle) and 1 cycle for non-memory ops.
REQ-034 There is no timeout; the FSM SHALL wait in REQ or WAIT indefinitely.

Reset
REQ-035 reset SHALL force IDLE and clear req_valid, req_wen, req_addr, req_wdata, req_wstrb, lsu_valid, lsu_rdata, lsu_err and all latched fields to 0, aborting any in-flight access; a response arriving after reset SHALL be ignored.

Configuration
REQ-036 Macro LSU_MISALIGN_CHECK_EN.
REQ-037 Defined: halfword access with addr[0]=1, or word access with addr[1:0]!=0, skips REQ/WAIT and goes directly to DONE with lsu_err=1, no bus request, and lsu_rdata unchanged.
REQ-038 Undefined: no check; the access is issued as in REQ-028 and REQ-030, and lsu_err reflects resp_err only.

Verification
REQ-039 lb, addr=0x80000003, resp_rdata=0x80FF1234 -> req_addr=0x80000000, req_wstrb=0, lsu_rdata=0xFFFFFF80, lsu_err=0.
REQ-040 sh, addr=0x80000002, wdata=0x0000BEEF, wmask=0011 -> req_wstrb=1100, req_wdata=0xBEEF0000, req_wen=1.
REQ-041 lhu, addr=0x10, req_ready held low 5 cycles -> req_* stable throughout; lsu_valid one cycle after resp_valid.
REQ-042 Non-memory op (mem_ren=mem_wen=0) -> lsu_valid the next cycle, no req_valid, lsu_rdata unchanged.
REQ-043 reset asserted while in WAIT, then resp_valid -> no lsu_valid; all outputs 0; the next load completes normally.
REQ-044 LSU_MISALIGN_CHECK_EN defined, lw at addr=0x6 -> no req_valid; lsu_valid=1 with lsu_err=1 the next cycle.
